seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (even, 4..32).
REQ-002 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ClearA_LoadB, input, 1, active-low; clears X/A and loads B from Din.
REQ-006 SHALL have port Run, input, 1, active-low; a high-to-low transition starts one multiply.
REQ-007 SHALL have port Din, input, WIDTH, switch operand; supplies both the B load and the multiplicand S.
REQ-008 SHALL have ports A and B, output, WIDTH each: product high and low halves.
REQ-009 SHALL have port X, output, 1: product sign/extension bit (carry when SIGNED=0).
REQ-010 SHALL have port Busy, output, 1: high while computing.
REQ-011 SHALL have port Done, output, 1: high from completion until Run returns high.

Function
REQ-012 SHALL implement states IDLE, ADD, SHIFT, HOLD.
REQ-013 SHALL, in IDLE with ClearA_LoadB low, set X=0, A=0, B=Din on each clock.
REQ-014 SHALL register Run and detect the falling edge; Run held low never restarts a multiply.
REQ-015 SHALL, on a detected Run falling edge in IDLE, latch Din into internal S, clear X/A, zero the bit counter, and enter ADD.
REQ-016 SHALL, in ADD: if B[0]=1, set {X,A} = A+S, or A-S on the final bit when SIGNED=1; otherwise hold. Then enter SHIFT.
REQ-017 SHALL, in SHIFT: shift {X,A,B} right by one with X replicated (SIGNED=1) or 0 shifted in (SIGNED=0); increment the counter; enter ADD, or HOLD after WIDTH shifts.
REQ-018 SHALL hold Busy high for exactly 2*WIDTH cycles; Done SHALL rise the cycle after Busy falls.
REQ-019 SHALL leave {A,B} = the full 2*WIDTH-bit product and X = product MSB (SIGNED=1) or 0 (SIGNED=0) on entry to HOLD.
REQ-020 SHALL stay in HOLD while Run is low, then return to IDLE with Done low the cycle after Run is sampled high.
REQ-021 SHALL ignore ClearA_LoadB and Din in ADD, SHIFT and HOLD.
REQ-022 SHALL compute the add/subtract at WIDTH+1 bits; no overflow is possible, including S = most-negative value.
REQ-023 SHALL give ClearA_LoadB priority when it is low in the same IDLE cycle as a Run falling edge; the Run edge is discarded.

Reset
REQ-024 SHALL, on Reset_n low at any time (including mid-multiply), asynchronously force IDLE, X=0, A=0, B=0, S=0, counter=0, Busy=0, Done=0, and the registered Run=1.

Configuration
REQ-025 SHALL, with HEX_DISPLAY_EN defined, add outputs AhexU, AhexL, BhexU, BhexL (7 bits each, active-low segments) showing A[7:0] and B[7:0].
REQ-026 SHALL, without HEX_DISPLAY_EN, omit those ports and the decode logic.

Structure
REQ-027 SHALL place the state enum type and the 7-segment code table in package seq_mult_pkg.
REQ-028 SHALL use one sub-module, hex_driver (4-bit nibble to 7-segment), instantiated only under HEX_DISPLAY_EN.

Verification (WIDTH=8)
REQ-029 SHALL check SIGNED=1, B=0xC5, Din=0xF9 at Run: result A=0x01, B=0x9D, X=0 (+413); Busy high exactly 16 cycles.
REQ-030 SHALL check SIGNED=1, B=0x3B, Din=0xF9: result A=0xFE, B=0x63, X=1 (-413).
REQ-031 SHALL check SIGNED=0, B=0xFF, Din=0xFF: result A=0xFE, B=0x01, X=0.
REQ-032 SHALL check SIGNED=1, B=0x80, Din=0x80: result A=0x40, B=0x00, X=0.
REQ-033 SHALL check that Run held low 40 cycles gives exactly one multiply, and Done stays high until Run rises.
REQ-034 SHALL check that Reset_n pulsed low at Busy cycle 5 clears all outputs immediately, and the next ClearA_LoadB then Run multiplies correctly.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and the
// active-low 7-segment code table (segment order gfedcba).
package seq_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    // Index 15 is the leftmost entry; the codes cover hex digits 0..F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment decoder, used by the optional hex display.
module hex_driver
    import seq_mult_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seq_multiplier.sv
// Add/shift sequential multiplier: {A,B} receives the 2*WIDTH-bit product of the
// loaded B and the multiplicand S. Define HEX_DISPLAY_EN for 7-segment outputs.
module seq_multiplier #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             ClearA_LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             X,
    output logic             Busy,
    output logic             Done
`ifdef HEX_DISPLAY_EN
    ,
    output logic [6:0]       AhexU,
    output logic [6:0]       AhexL,
    output logic [6:0]       BhexU,
    output logic [6:0]       BhexL
`endif
);

    import seq_mult_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic               r_x, w_x_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [WIDTH-1:0]   r_s, w_s_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_run;
    logic               w_run_fall;
    logic               w_sub;
    logic signed [WIDTH:0] w_sum;

    // {X,A} is a (WIDTH+1)-bit accumulator, so neither the add nor the
    // final-bit subtract of the most-negative S can overflow.
    function automatic logic signed [WIDTH:0] addsub(
        input logic signed [WIDTH:0] acc,
        input logic [WIDTH-1:0]      s,
        input logic                  sub
    );
        logic signed [WIDTH:0] ext_s;
        ext_s = (SIGNED != 0) ? {s[WIDTH-1], s} : {1'b0, s};
        return sub ? (acc - ext_s) : (acc + ext_s);
    endfunction

    assign w_run_fall = r_run & ~Run;
    assign w_sub      = (SIGNED != 0) && (r_cnt == LAST_BIT);
    assign w_sum      = addsub({r_x, r_a}, r_s, w_sub);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!ClearA_LoadB) begin
                    w_x_nxt = 1'b0;
                    w_a_nxt = '0;
                    w_b_nxt = Din;
                end else if (w_run_fall) begin
                    w_s_nxt     = Din;
                    w_x_nxt     = 1'b0;
                    w_a_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (r_b[0]) begin
                    {w_x_nxt, w_a_nxt} = w_sum;
                end
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // The old X always lands in A's MSB; only the new X differs by mode.
                w_x_nxt     = (SIGNED != 0) ? r_x : 1'b0;
                w_a_nxt     = {r_x, r_a[WIDTH-1:1]};
                w_b_nxt     = {r_a[0], r_b[WIDTH-1:1]};
                w_cnt_nxt   = r_cnt + 1'b1;
                w_state_nxt = (r_cnt == LAST_BIT) ? S_HOLD : S_ADD;
            end
            S_HOLD: begin
                if (Run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_x     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run   <= Run;
        end
    end

    assign A    = r_a;
    assign B    = r_b;
    assign X    = r_x;
    assign Busy = (r_state == S_ADD) || (r_state == S_SHIFT);
    assign Done = (r_state == S_HOLD);

`ifdef HEX_DISPLAY_EN
    logic [7:0] w_a_byte;
    logic [7:0] w_b_byte;

    // Narrow operands are zero-extended so the display always shows a full byte.
    generate
        if (WIDTH >= 8) begin : g_byte_wide
            assign w_a_byte = r_a[7:0];
            assign w_b_byte = r_b[7:0];
        end else begin : g_byte_narrow
            assign w_a_byte = {{(8-WIDTH){1'b0}}, r_a};
            assign w_b_byte = {{(8-WIDTH){1'b0}}, r_b};
        end
    endgenerate

    hex_driver u_hex_au (.i_nibble(w_a_byte[7:4]), .o_seg(AhexU));
    hex_driver u_hex_al (.i_nibble(w_a_byte[3:0]), .o_seg(AhexL));
    hex_driver u_hex_bu (.i_nibble(w_b_byte[7:4]), .o_seg(BhexU));
    hex_driver u_hex_bl (.i_nibble(w_b_byte[3:0]), .o_seg(BhexL));
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: signed and unsigned 8-bit multipliers share one stimulus
// stream and are compared against integer products computed by the bench.
module tb_seq_multiplier;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         ClearA_LoadB;
    logic         Run;
    logic [W-1:0] Din;

    logic [W-1:0] a_s, b_s, a_u, b_u;
    logic         x_s, busy_s, done_s, x_u, busy_u, done_u;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W), .SIGNED(1)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .ClearA_LoadB(ClearA_LoadB), .Run(Run),
        .Din(Din), .A(a_s), .B(b_s), .X(x_s), .Busy(busy_s), .Done(done_s)
    );

    seq_multiplier #(.WIDTH(W), .SIGNED(0)) dut_u (
        .Clk(Clk), .Reset_n(Reset_n), .ClearA_LoadB(ClearA_LoadB), .Run(Run),
        .Din(Din), .A(a_u), .B(b_u), .X(x_u), .Busy(busy_u), .Done(done_u)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_products(input string tag, input logic [W-1:0] bv, input logic [W-1:0] sv);
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0]        pu;
        ps = $signed({{W{bv[W-1]}}, bv}) * $signed({{W{sv[W-1]}}, sv});
        pu = {{W{1'b0}}, bv} * {{W{1'b0}}, sv};
        check_val({tag, " signed A"}, 32'(a_s), 32'(ps[2*W-1:W]));
        check_val({tag, " signed B"}, 32'(b_s), 32'(ps[W-1:0]));
        check_val({tag, " signed X"}, 32'(x_s), 32'(ps[2*W-1]));
        check_val({tag, " unsigned A"}, 32'(a_u), 32'(pu[2*W-1:W]));
        check_val({tag, " unsigned B"}, 32'(b_u), 32'(pu[W-1:0]));
        check_val({tag, " unsigned X"}, 32'(x_u), 32'(0));
    endtask

    task automatic load_b(input logic [W-1:0] bv);
        Din          = bv;
        ClearA_LoadB = 1'b0;
        step();
        ClearA_LoadB = 1'b1;
        Din          = W'($urandom);
        step();
    endtask

    // Loads B, starts one multiply with multiplicand sv, keeps Run low for
    // hold_n cycles after completion, then releases Run.
    task automatic do_mult(input string tag, input logic [W-1:0] bv, input logic [W-1:0] sv,
                           input int hold_n);
        int busy_cnt;
        load_b(bv);
        check_val({tag, " loaded B"}, 32'(b_s), 32'(bv));
        check_val({tag, " cleared A"}, 32'(a_u), 32'(0));
        Din = sv;
        Run = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            // Operand and load inputs are garbage during the multiply.
            Din          = W'($urandom);
            ClearA_LoadB = 1'($urandom);
            if (busy_s) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        check_val({tag, " busy cycles"}, 32'(busy_cnt), 32'(2*W));
        check_val({tag, " done"}, 32'(done_s), 32'(1));
        check_val({tag, " done unsigned"}, 32'(done_u), 32'(1));
        for (int i = 0; i < hold_n; i++) begin
            step();
            Din          = W'($urandom);
            ClearA_LoadB = 1'($urandom);
        end
        ClearA_LoadB = 1'b1;
        check_products(tag, bv, sv);
        if (hold_n > 0) begin
            check_val({tag, " done held"}, 32'(done_s), 32'(1));
            check_val({tag, " no restart"}, 32'(busy_s), 32'(0));
        end
        Run = 1'b1;
        step();
        check_val({tag, " done cleared"}, 32'(done_s), 32'(0));
        check_products({tag, " idle"}, bv, sv);
    endtask

    initial begin
        int bc;
        Reset_n      = 1'b0;
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        Din          = '0;
        #12;
        check_val("reset A", 32'(a_s), 32'(0));
        check_val("reset B", 32'(b_s), 32'(0));
        check_val("reset X", 32'(x_s), 32'(0));
        check_val("reset busy", 32'(busy_s), 32'(0));
        check_val("reset done", 32'(done_s), 32'(0));
        step();
        Reset_n = 1'b1;
        step();

        do_mult("c5xf9", 8'hC5, 8'hF9, 0);
        do_mult("3bxf9", 8'h3B, 8'hF9, 2);
        do_mult("ffxff", 8'hFF, 8'hFF, 1);
        do_mult("80x80", 8'h80, 8'h80, 0);
        do_mult("run_low_40", 8'h5A, 8'hA7, 40 - 2*W - 1);

        // Asynchronous reset in the middle of a multiply.
        load_b(8'h77);
        Din = 8'h99;
        Run = 1'b0;
        bc  = 0;
        for (int i = 0; i < 50 && bc < 5; i++) begin
            step();
            if (busy_s) bc++;
        end
        check_val("midrun busy", 32'(busy_s), 32'(1));
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("midrun reset A", 32'(a_s), 32'(0));
        check_val("midrun reset B", 32'(b_s), 32'(0));
        check_val("midrun reset X", 32'(x_s), 32'(0));
        check_val("midrun reset busy", 32'(busy_s), 32'(0));
        check_val("midrun reset done", 32'(done_s), 32'(0));
        check_val("midrun reset unsigned B", 32'(b_u), 32'(0));
        Run = 1'b1;
        step();
        Reset_n = 1'b1;
        step();
        do_mult("after_reset", 8'h77, 8'h99, 0);

        // Load and Run edge in the same IDLE cycle: the load wins, no multiply.
        Din          = 8'h21;
        ClearA_LoadB = 1'b0;
        Run          = 1'b0;
        step();
        ClearA_LoadB = 1'b1;
        step();
        check_val("load priority busy", 32'(busy_s), 32'(0));
        check_val("load priority B", 32'(b_s), 32'(8'h21));
        Run = 1'b1;
        step();

        do_mult("zero_b", 8'h00, 8'h80, 0);
        do_mult("neg_edge", 8'h7F, 8'h80, 0);
        for (int k = 0; k < 16; k++) begin
            do_mult($sformatf("rand%0d", k), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
